dcache_wport_arbiter: RTL and testbench
=======================================

DCACHE_WPORT_ARBITER -- requirements
Module: dcache_wport_arbiter

Interface
REQ-001 Parameter NUM_LINES, default 32, number of cache lines walked by the flush sequence.
REQ-002 Parameter STARVE_LIMIT, default 4, consecutive blocked store cycles before the store is promoted.
REQ-003 The block SHALL use one clock, and reset SHALL be synchronous and active-low.
REQ-004 clock  in  1  rising-edge clock.
REQ-005 reset  in  1  synchronous, active-low reset.
REQ-006 wb_valid/wb_addr/wb_data/wb_dirty  in  1/64/64/1  MSHR write-back write request.
REQ-007 wb_ready  out  1  write-back request accepted this cycle.
REQ-008 fill_valid/fill_addr/fill_data/fill_dirty  in  1/64/64/1  memory fill write request.
REQ-009 fill_ready  out  1  fill request accepted this cycle.
REQ-010 sq_valid/sq_addr/sq_data  in  1/64/64  store-queue write request.
REQ-011 sq_ready  out  1  store request accepted this cycle.
REQ-012 flush_req  in  1  program done; request a full cache flush.
REQ-013 mshr_valid  in  1  MSHR can accept an eviction.
REQ-014 mshr_empty  in  1  MSHR has no outstanding entries.
REQ-015 wr_en/wr_addr/wr_data/wr_dirty/wr_valid  out  1/64/64/1/1  registered cache write port.
REQ-016 grant_src  out  3  WPORT_SRC of the write currently on the port.
REQ-017 flush_busy  out  1  high in FLUSH or DRAIN.
REQ-018 halt_pipeline  out  1  flush complete; high in HALT.

Function
REQ-019 A request SHALL transfer on valid&ready; each ready SHALL be combinational, with at most one ready high per cycle.
REQ-020 wb and fill SHALL be grantable only when mshr_valid=1.
REQ-021 RUN priority SHALL be wb > fill > sq; when starve_cnt==STARVE_LIMIT, sq SHALL take top priority.
REQ-022 starve_cnt SHALL increment on every cycle with sq_valid&!sq_ready, saturate at STARVE_LIMIT, and clear on sq grant.
REQ-023 A granted request SHALL appear on wr_* exactly one cycle later, with wr_en=1 for that single cycle.
REQ-024 For granted writes, wr_dirty SHALL be wb_dirty, fill_dirty, or 1 for sq, and wr_valid SHALL be 1.
REQ-025 With no grant, the next cycle SHALL have wr_en=0 and grant_src=SRC_NONE, with addr/data holding their last values.
REQ-026 FSM RUN→FLUSH SHALL occur on flush_req=1.
REQ-027 In the flush_req cycle, RUN arbitration SHALL still apply, so a store may be granted.
REQ-028 In FLUSH, sq_ready SHALL be 0 and wb/fill SHALL keep priority over the walker.
REQ-029 In FLUSH, when neither wb nor fill is granted and mshr_valid=1, the walker SHALL issue wr_addr={line_idx,3'b000}, wr_valid=0, wr_dirty=0, grant_src=SRC_FLUSH, then increment line_idx.
REQ-030 FLUSH→DRAIN SHALL occur after line_idx==NUM_LINES-1 is issued.
REQ-031 In DRAIN, only wb and fill SHALL be grantable; DRAIN→HALT SHALL occur when mshr_empty=1 and no wb/fill is granted that cycle.
REQ-032 HALT SHALL be sticky until reset, with all readies 0, wr_en=0, and halt_pipeline=1.
REQ-033 flush_req SHALL be ignored outside RUN.
REQ-034 line_idx width SHALL be $clog2(NUM_LINES) and SHALL never wrap past NUM_LINES-1.

Reset
REQ-035 On reset=0 at a clock edge: state=RUN, line_idx=0, starve_cnt=0, wr_en=0, wr_addr=0, wr_data=0, wr_dirty=0, wr_valid=0, grant_src=SRC_NONE, flush_busy=0, halt_pipeline=0.
REQ-036 Reset asserted mid-FLUSH or in DRAIN SHALL abort the flush and return to RUN with line_idx=0.

Structure
REQ-037 dcache_pkg SHALL hold SASS_ADDR, the WPORT_SRC enum (SRC_NONE, SRC_WB, SRC_FILL, SRC_ST, SRC_FLUSH) and the FSM state enum (RUN, FLUSH, DRAIN, HALT).
REQ-038 Line counting SHALL be in sub-module dcache_flush_walker (en, line_idx, last), instantiated once.

Verification
REQ-039 wb, fill and sq all valid with mshr_valid=1 → wb granted; next cycle wr_en=1, grant_src=SRC_WB.
REQ-040 sq_valid held with fill_valid held for 4 cycles → sq granted on cycle 5, starve_cnt=0 after.
REQ-041 wb_valid=1 with mshr_valid=0 → wb_ready=0; sq_valid=1 is granted instead.
REQ-042 flush_req with NUM_LINES=4 and mshr_valid=1 → 4 walker writes at addr 0x0, 0x8, 0x10, 0x18 with wr_valid=0, then DRAIN.
REQ-043 DRAIN with mshr_empty=0 for 3 cycles, then 1 → HALT one cycle later, halt_pipeline=1, sq_ready=0 thereafter.
REQ-044 reset=0 while line_idx=2 in FLUSH → RUN, line_idx=0, all outputs at reset values.

Source files
------------

// File: rtl/dcache_pkg.sv
// dcache_pkg: shared widths, write-port source tags and arbiter FSM states.
package dcache_pkg;
    localparam int SASS_ADDR = 64;
    localparam int SASS_DATA = 64;
    typedef enum logic [2:0] {SRC_NONE, SRC_WB, SRC_FILL, SRC_ST, SRC_FLUSH} wport_src_e;
    typedef enum logic [1:0] {RUN, FLUSH, DRAIN, HALT} state_e;
endpackage

// File: rtl/dcache_wport_arbiter_if.sv
// dcache_wport_arbiter_if: requester handshakes, MSHR status and the registered cache write port.
interface dcache_wport_arbiter_if;
    import dcache_pkg::*;
    logic                 wb_valid, wb_dirty, wb_ready;
    logic [SASS_ADDR-1:0] wb_addr;
    logic [SASS_DATA-1:0] wb_data;
    logic                 fill_valid, fill_dirty, fill_ready;
    logic [SASS_ADDR-1:0] fill_addr;
    logic [SASS_DATA-1:0] fill_data;
    logic                 sq_valid, sq_ready;
    logic [SASS_ADDR-1:0] sq_addr;
    logic [SASS_DATA-1:0] sq_data;
    logic                 flush_req, mshr_valid, mshr_empty;
    logic                 wr_en, wr_dirty, wr_valid;
    logic [SASS_ADDR-1:0] wr_addr;
    logic [SASS_DATA-1:0] wr_data;
    wport_src_e           grant_src;
    logic                 flush_busy, halt_pipeline;
    modport slave (
        input  wb_valid, wb_addr, wb_data, wb_dirty,
        input  fill_valid, fill_addr, fill_data, fill_dirty,
        input  sq_valid, sq_addr, sq_data,
        input  flush_req, mshr_valid, mshr_empty,
        output wb_ready, fill_ready, sq_ready,
        output wr_en, wr_addr, wr_data, wr_dirty, wr_valid, grant_src, flush_busy, halt_pipeline
    );
    modport master (
        output wb_valid, wb_addr, wb_data, wb_dirty,
        output fill_valid, fill_addr, fill_data, fill_dirty,
        output sq_valid, sq_addr, sq_data,
        output flush_req, mshr_valid, mshr_empty,
        input  wb_ready, fill_ready, sq_ready,
        input  wr_en, wr_addr, wr_data, wr_dirty, wr_valid, grant_src, flush_busy, halt_pipeline
    );
endinterface

// File: rtl/dcache_flush_walker.sv
// dcache_flush_walker: line counter for the flush sequence; stops at the last line instead of wrapping.
module dcache_flush_walker #(
    parameter int NUM_LINES = 32,
    parameter int IW = (NUM_LINES > 1) ? $clog2(NUM_LINES) : 1
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          en,
    output logic [IW-1:0] line_idx,
    output logic          last
);
    assign last = line_idx == IW'(NUM_LINES - 1);
    always_ff @(posedge clock) begin
        if (!reset) line_idx <= '0;
        else if (en && !last) line_idx <= line_idx + IW'(1);
    end
endmodule

// File: rtl/dcache_wport_arbiter.sv
// dcache_wport_arbiter: arbitrates write-back, fill and store writes onto one registered cache write port,
// then walks every line on flush, drains the MSHR and halts the pipeline.
module dcache_wport_arbiter
    import dcache_pkg::*;
#(
    parameter int NUM_LINES    = 32,
    parameter int STARVE_LIMIT = 4
) (
    input logic              clock,
    input logic              reset,
    dcache_wport_arbiter_if.slave bus
);
    localparam int IW = (NUM_LINES > 1) ? $clog2(NUM_LINES) : 1;
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    state_e        state;
    logic [SW-1:0] starve_cnt;
    logic [IW-1:0] line_idx;
    logic          last, wb_ok, fill_ok, sq_pri, wb_g, fill_g, sq_g, walk;
    // A starved store in RUN overrides the write-back/fill priority.
    assign wb_ok   = bus.wb_valid && bus.mshr_valid && state != HALT;
    assign fill_ok = bus.fill_valid && bus.mshr_valid && state != HALT;
    assign sq_pri  = state == RUN && bus.sq_valid && starve_cnt == SW'(STARVE_LIMIT);
    assign wb_g    = wb_ok && !sq_pri;
    assign fill_g  = fill_ok && !wb_ok && !sq_pri;
    assign sq_g    = state == RUN && bus.sq_valid && !wb_g && !fill_g;
    assign walk    = state == FLUSH && bus.mshr_valid && !wb_ok && !fill_ok;
    assign bus.wb_ready   = wb_g;
    assign bus.fill_ready = fill_g;
    assign bus.sq_ready   = sq_g;
    dcache_flush_walker #(.NUM_LINES(NUM_LINES)) u_walker (
        .clock(clock), .reset(reset), .en(walk), .line_idx(line_idx), .last(last)
    );
    always_ff @(posedge clock) begin
        if (!reset) begin
            state             <= RUN;
            starve_cnt        <= '0;
            bus.wr_en         <= 1'b0;
            bus.wr_addr       <= '0;
            bus.wr_data       <= '0;
            bus.wr_dirty      <= 1'b0;
            bus.wr_valid      <= 1'b0;
            bus.grant_src     <= SRC_NONE;
            bus.flush_busy    <= 1'b0;
            bus.halt_pipeline <= 1'b0;
        end else begin
            starve_cnt    <= sq_g ? '0 : (bus.sq_valid && starve_cnt != SW'(STARVE_LIMIT)) ? starve_cnt + SW'(1) : starve_cnt;
            bus.wr_en     <= wb_g || fill_g || sq_g || walk;
            bus.wr_valid  <= wb_g || fill_g || sq_g;
            bus.wr_dirty  <= wb_g ? bus.wb_dirty : fill_g ? bus.fill_dirty : sq_g;
            bus.grant_src <= wb_g ? SRC_WB : fill_g ? SRC_FILL : sq_g ? SRC_ST : walk ? SRC_FLUSH : SRC_NONE;
            bus.wr_addr   <= wb_g ? bus.wb_addr : fill_g ? bus.fill_addr : sq_g ? bus.sq_addr :
                             walk ? SASS_ADDR'({line_idx, 3'b000}) : bus.wr_addr;
            bus.wr_data   <= wb_g ? bus.wb_data : fill_g ? bus.fill_data : sq_g ? bus.sq_data :
                             walk ? '0 : bus.wr_data;
            case (state)
                RUN: if (bus.flush_req) begin
                    state          <= FLUSH;
                    bus.flush_busy <= 1'b1;
                end
                FLUSH: if (walk && last) state <= DRAIN;
                DRAIN: if (bus.mshr_empty && !wb_g && !fill_g) begin
                    state             <= HALT;
                    bus.flush_busy    <= 1'b0;
                    bus.halt_pipeline <= 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_dcache_wport_arbiter.sv
// tb_dcache_wport_arbiter: directed checks of arbitration, starvation, flush walk, drain, halt and reset.
module tb_dcache_wport_arbiter;
  import dcache_pkg::*;
  logic clock = 1'b0;
  logic reset = 1'b0;
  int checks = 0;
  int errors = 0;
  dcache_wport_arbiter_if bus();
  dcache_wport_arbiter #(.NUM_LINES(4), .STARVE_LIMIT(4)) dut (.clock(clock), .reset(reset), .bus(bus));
  always #5 clock = ~clock;
  task automatic tick;
    @(posedge clock);
    #1;
  endtask
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  initial begin
    {bus.wb_valid, bus.wb_dirty, bus.fill_valid, bus.fill_dirty, bus.sq_valid} = '0;
    {bus.flush_req, bus.mshr_valid, bus.mshr_empty} = '0;
    bus.wb_addr = '0; bus.wb_data = '0; bus.fill_addr = '0; bus.fill_data = '0;
    bus.sq_addr = '0; bus.sq_data = '0;
    tick; tick;
    chk("rst_wr_en", bus.wr_en, 1'b0);
    chk("rst_wr_addr", bus.wr_addr, 64'h0);
    chk("rst_src", bus.grant_src, SRC_NONE);
    chk("rst_busy", bus.flush_busy, 1'b0);
    chk("rst_halt", bus.halt_pipeline, 1'b0);
    reset = 1'b1;
    bus.wb_valid = 1; bus.wb_addr = 64'h100; bus.wb_data = 64'hAAAA; bus.wb_dirty = 1;
    bus.fill_valid = 1; bus.fill_addr = 64'h300; bus.fill_data = 64'hF0; bus.fill_dirty = 0;
    bus.sq_valid = 1; bus.sq_addr = 64'h200; bus.sq_data = 64'h55; bus.mshr_valid = 1;
    #1;
    chk("prio_wb_ready", bus.wb_ready, 1'b1);
    chk("prio_fill_ready", bus.fill_ready, 1'b0);
    chk("prio_sq_ready", bus.sq_ready, 1'b0);
    tick;
    chk("wb_wr_en", bus.wr_en, 1'b1);
    chk("wb_src", bus.grant_src, SRC_WB);
    chk("wb_addr", bus.wr_addr, 64'h100);
    chk("wb_data", bus.wr_data, 64'hAAAA);
    chk("wb_dirty", bus.wr_dirty, 1'b1);
    chk("wb_valid", bus.wr_valid, 1'b1);
    bus.fill_valid = 0; bus.mshr_valid = 0;
    #1;
    chk("nomshr_wb_ready", bus.wb_ready, 1'b0);
    chk("nomshr_sq_ready", bus.sq_ready, 1'b1);
    tick;
    chk("sq_src", bus.grant_src, SRC_ST);
    chk("sq_addr", bus.wr_addr, 64'h200);
    chk("sq_dirty", bus.wr_dirty, 1'b1);
    chk("sq_starve_clr", dut.starve_cnt, 3'd0);
    bus.wb_valid = 0; bus.sq_valid = 0;
    tick;
    chk("idle_wr_en", bus.wr_en, 1'b0);
    chk("idle_src", bus.grant_src, SRC_NONE);
    chk("idle_addr_hold", bus.wr_addr, 64'h200);
    chk("idle_data_hold", bus.wr_data, 64'h55);
    bus.fill_valid = 1; bus.sq_valid = 1; bus.sq_addr = 64'h400; bus.mshr_valid = 1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("starve_fill_ready", bus.fill_ready, 1'b1);
      chk("starve_sq_blocked", bus.sq_ready, 1'b0);
      tick;
      chk("fill_src", bus.grant_src, SRC_FILL);
    end
    chk("fill_dirty", bus.wr_dirty, 1'b0);
    chk("starve_sat", dut.starve_cnt, 3'd4);
    #1;
    chk("starve_sq_ready", bus.sq_ready, 1'b1);
    chk("starve_fill_blocked", bus.fill_ready, 1'b0);
    tick;
    chk("starve_sq_src", bus.grant_src, SRC_ST);
    chk("starve_cleared", dut.starve_cnt, 3'd0);
    bus.fill_valid = 0; bus.flush_req = 1; bus.sq_addr = 64'h500;
    #1;
    chk("flushreq_sq_ready", bus.sq_ready, 1'b1);
    tick;
    chk("flushreq_sq_src", bus.grant_src, SRC_ST);
    chk("flush_busy", bus.flush_busy, 1'b1);
    bus.flush_req = 0;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("flush_sq_ready", bus.sq_ready, 1'b0);
      tick;
      chk("walk_wr_en", bus.wr_en, 1'b1);
      chk("walk_src", bus.grant_src, SRC_FLUSH);
      chk("walk_addr", bus.wr_addr, 64'(i * 8));
      chk("walk_valid", bus.wr_valid, 1'b0);
      chk("walk_dirty", bus.wr_dirty, 1'b0);
    end
    chk("drain_state", dut.state, DRAIN);
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("drain_hold", dut.state, DRAIN);
      chk("drain_wr_en", bus.wr_en, 1'b0);
    end
    chk("drain_busy", bus.flush_busy, 1'b1);
    bus.mshr_empty = 1;
    tick;
    chk("halt_state", dut.state, HALT);
    chk("halt_pipeline", bus.halt_pipeline, 1'b1);
    chk("halt_busy", bus.flush_busy, 1'b0);
    bus.wb_valid = 1; bus.flush_req = 1;
    #1;
    chk("halt_sq_ready", bus.sq_ready, 1'b0);
    chk("halt_wb_ready", bus.wb_ready, 1'b0);
    tick;
    chk("halt_wr_en", bus.wr_en, 1'b0);
    chk("halt_sticky", bus.halt_pipeline, 1'b1);
    reset = 0; bus.wb_valid = 0; bus.sq_valid = 0; bus.mshr_empty = 0;
    tick;
    reset = 1;
    chk("rerst_halt", bus.halt_pipeline, 1'b0);
    tick;
    chk("reflush_busy", bus.flush_busy, 1'b1);
    bus.flush_req = 0; bus.wb_valid = 1;
    #1;
    chk("flush_wb_over_walk", bus.wb_ready, 1'b1);
    tick;
    chk("flush_wb_src", bus.grant_src, SRC_WB);
    bus.wb_valid = 0;
    tick; tick;
    chk("walk_idx2", dut.u_walker.line_idx, 2'd2);
    chk("walk_addr8", bus.wr_addr, 64'h8);
    reset = 0;
    tick;
    chk("abort_state", dut.state, RUN);
    chk("abort_idx", dut.u_walker.line_idx, 2'd0);
    chk("abort_wr_en", bus.wr_en, 1'b0);
    chk("abort_addr", bus.wr_addr, 64'h0);
    chk("abort_data", bus.wr_data, 64'h0);
    chk("abort_src", bus.grant_src, SRC_NONE);
    chk("abort_busy", bus.flush_busy, 1'b0);
    chk("abort_valid", bus.wr_valid, 1'b0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
